// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared types and constants for the sprite mapper slice.
//               Holds the screen geometry, the coordinate width, the RGB444
//               pixel struct and the closed-form contents of the per-sprite
//               index ROM and palette.
// Revision    : 1.0  initial release
// ============================================================================
package sprite_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Index ROM image: texel index for a flat ROM address. Stands in for the
    // generated ROM IP so the block elaborates on its own. Supports idx_w<=8.
    function automatic logic [7:0] rom_lookup(input logic [31:0] addr,
                                              input int          idx_w);
        logic [31:0] t;
        logic [31:0] mask;
        t    = addr * 32'd7 + 32'd3;
        mask = (32'd1 << idx_w) - 32'd1;
        return 8'(t & mask);
    endfunction

    // Palette image: RGB444 colour for a palette index.
    function automatic rgb444_t palette_lookup(input logic [7:0] idx);
        rgb444_t c;
        c.r = idx[3:0];
        c.g = ~idx[3:0];
        c.b = {idx[4:2], 1'b1};
        return c;
    endfunction

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_if
// Description : Pixel-stream bundle between the VGA controller side and one
//               sprite_mapper instance.
//               Controller -> mapper : DrawX, DrawY, blank, pos_x, pos_y,
//                                      anim_en (and mirror when
//                                      SPRITE_MIRROR_EN is defined)
//               Mapper -> colour mux : red, green, blue, hit
//               master modport = driver of coordinates, slave = mapper.
// Options     : SPRITE_MIRROR_EN adds the 1-bit mirror request.
// Revision    : 1.0  initial release
// ============================================================================
interface sprite_if;
    import sprite_pkg::*;

    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic               blank;
    logic [COORD_W-1:0] pos_x;
    logic [COORD_W-1:0] pos_y;
    logic               anim_en;
`ifdef SPRITE_MIRROR_EN
    logic               mirror;
`endif
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic               hit;

    modport master (
        output DrawX, DrawY, blank, pos_x, pos_y, anim_en,
`ifdef SPRITE_MIRROR_EN
        output mirror,
`endif
        input  red, green, blue, hit
    );

    modport slave (
        input  DrawX, DrawY, blank, pos_x, pos_y, anim_en,
`ifdef SPRITE_MIRROR_EN
        input  mirror,
`endif
        output red, green, blue, hit
    );

endinterface : sprite_if
`default_nettype wire

// File: rtl/sprite_anim_ctr.sv
`default_nettype none
// ============================================================================
// Module      : sprite_anim_ctr
// Description : Frame-start detector plus animation hold/frame counters.
//               frame_start is combinational and fires on the first cycle
//               the scan sits at (0,0); holding (0,0) does not re-fire.
//               hold_cnt counts frame starts (while anim_en) up to
//               FRAME_HOLD-1, then frame_idx advances and wraps at
//               NUM_FRAMES-1.
// Ports       : vga_clk, Reset      clock / async active-high reset
//               DrawX, DrawY        current scan coordinates
//               anim_en             allow animation to advance
//               frame_start         first cycle of a new video frame
//               frame_idx           current animation frame (registered)
// Revision    : 1.0  initial release
// ============================================================================
module sprite_anim_ctr
    import sprite_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    parameter int FIDX_W     = 2
) (
    input  wire logic               vga_clk,
    input  wire logic               Reset,
    input  wire logic [COORD_W-1:0] DrawX,
    input  wire logic [COORD_W-1:0] DrawY,
    input  wire logic               anim_en,
    output logic                    frame_start,
    output logic [FIDX_W-1:0]       frame_idx
);

    logic [COORD_W-1:0] r_prev_x;
    logic [COORD_W-1:0] r_prev_y;
    logic [7:0]         r_hold_cnt;
    logic [FIDX_W-1:0]  r_frame_idx;

    logic w_at_origin;
    logic w_prev_origin;
    logic w_hold_wrap;
    logic w_frame_wrap;

    always_comb begin
        w_at_origin   = (DrawX == '0) && (DrawY == '0);
        w_prev_origin = (r_prev_x == '0) && (r_prev_y == '0);
        w_hold_wrap   = (r_hold_cnt == 8'(FRAME_HOLD - 1));
        // With NUM_FRAMES=1 this compares against 0, so the index never moves.
        w_frame_wrap  = (r_frame_idx == FIDX_W'(NUM_FRAMES - 1));
    end

    assign frame_start = w_at_origin && !w_prev_origin;
    assign frame_idx   = r_frame_idx;

    // Previous coordinates reset to all-ones so the first (0,0) after reset
    // is recognised as a frame start.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            r_prev_x <= '1;
            r_prev_y <= '1;
        end else begin
            r_prev_x <= DrawX;
            r_prev_y <= DrawY;
        end
    end

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            r_hold_cnt  <= 8'd0;
            r_frame_idx <= '0;
        end else if (frame_start && anim_en) begin
            if (w_hold_wrap) begin
                r_hold_cnt  <= 8'd0;
                r_frame_idx <= w_frame_wrap ? '0 : r_frame_idx + FIDX_W'(1);
            end else begin
                r_hold_cnt  <= r_hold_cnt + 8'd1;
            end
        end
    end

endmodule : sprite_anim_ctr
`default_nettype wire

// File: rtl/sprite_mapper.sv
`default_nettype none
// ============================================================================
// Module      : sprite_mapper
// Description : Maps the current VGA scan position onto a movable,
//               integer-scaled, animated sprite and returns registered RGB
//               plus a per-pixel hit flag. Fixed 2-cycle latency, one pixel
//               per cycle.
//                 cycle n   : containment + ROM address (combinational)
//                 cycle n+1 : index ROM read, inside/blank delayed
//                 cycle n+2 : palette colour / hit registered at outputs
// Ports       : vga_clk   pixel clock
//               Reset     async active-high reset
//               bus       sprite_if.slave (DrawX/DrawY/blank/pos_x/pos_y/
//                         anim_en[/mirror] in, red/green/blue/hit out)
// Options     : SPRITE_MIRROR_EN adds a frame-latched horizontal flip.
// Revision    : 1.0  initial release
// ============================================================================
module sprite_mapper
    import sprite_pkg::*;
#(
    parameter int SPR_W           = 21,
    parameter int SPR_H           = 24,
    parameter int SCALE_LOG2      = 2,
    parameter int NUM_FRAMES      = 4,
    parameter int FRAME_HOLD      = 8,
    parameter int IDX_W           = 5,
    parameter int TRANSPARENT_IDX = 0
) (
    input  wire logic vga_clk,
    input  wire logic Reset,
    sprite_if.slave   bus
);

    localparam int c_ext_w     = COORD_W + 1;
    localparam int c_span_x    = SPR_W << SCALE_LOG2;
    localparam int c_span_y    = SPR_H << SCALE_LOG2;
    localparam int c_frame_sz  = SPR_W * SPR_H;
    localparam int c_rom_depth = NUM_FRAMES * c_frame_sz;
    localparam int c_addr_w    = (c_rom_depth > 1) ? $clog2(c_rom_depth) : 1;
    localparam int c_fidx_w    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    // ------------------------------------------------------------------
    // Frame-start detection and animation counters
    // ------------------------------------------------------------------
    logic                w_frame_start;
    logic [c_fidx_w-1:0] w_frame_idx;

    sprite_anim_ctr #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .FIDX_W     (c_fidx_w)
    ) u_anim_ctr (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .DrawX       (bus.DrawX),
        .DrawY       (bus.DrawY),
        .anim_en     (bus.anim_en),
        .frame_start (w_frame_start),
        .frame_idx   (w_frame_idx)
    );

    // ------------------------------------------------------------------
    // Position latched once per frame so a moving object never tears
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] r_px;
    logic [COORD_W-1:0] r_py;

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            r_px <= '0;
            r_py <= '0;
        end else if (w_frame_start) begin
            r_px <= bus.pos_x;
            r_py <= bus.pos_y;
        end
    end

    // ------------------------------------------------------------------
    // Containment: one extra bit so px + span cannot wrap past 1023
    // ------------------------------------------------------------------
    logic [c_ext_w-1:0] w_x_ext;
    logic [c_ext_w-1:0] w_y_ext;
    logic [c_ext_w-1:0] w_px_ext;
    logic [c_ext_w-1:0] w_py_ext;
    logic [c_ext_w-1:0] w_x_end;
    logic [c_ext_w-1:0] w_y_end;
    logic               w_inside;

    assign w_x_ext  = {1'b0, bus.DrawX};
    assign w_y_ext  = {1'b0, bus.DrawY};
    assign w_px_ext = {1'b0, r_px};
    assign w_py_ext = {1'b0, r_py};
    assign w_x_end  = w_px_ext + c_ext_w'(c_span_x);
    assign w_y_end  = w_py_ext + c_ext_w'(c_span_y);

    assign w_inside = (w_x_ext >= w_px_ext) && (w_x_ext < w_x_end) &&
                      (w_y_ext >= w_py_ext) && (w_y_ext < w_y_end);

    // ------------------------------------------------------------------
    // Local texel coordinates; only meaningful while w_inside is set
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] w_dx;
    logic [COORD_W-1:0] w_dy;
    logic [COORD_W-1:0] w_lx;
    logic [COORD_W-1:0] w_ly;
    logic [COORD_W-1:0] w_lx_eff;

    assign w_dx = bus.DrawX - r_px;
    assign w_dy = bus.DrawY - r_py;
    assign w_lx = w_dx >> SCALE_LOG2;
    assign w_ly = w_dy >> SCALE_LOG2;

`ifdef SPRITE_MIRROR_EN
    logic r_mirror;

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            r_mirror <= 1'b0;
        end else if (w_frame_start) begin
            r_mirror <= bus.mirror;
        end
    end

    assign w_lx_eff = r_mirror ? (COORD_W'(SPR_W - 1) - w_lx) : w_lx;
`else
    assign w_lx_eff = w_lx;
`endif

    // ------------------------------------------------------------------
    // Flat ROM address: frames stored back to back, row-major texels.
    // Forced to 0 outside the sprite so the ROM sees a quiet address.
    // ------------------------------------------------------------------
    logic [c_addr_w-1:0] w_addr_calc;
    logic [c_addr_w-1:0] w_rom_addr;

    assign w_addr_calc = c_addr_w'(32'(w_frame_idx) * 32'(c_frame_sz) +
                                   32'(w_ly) * 32'(SPR_W) +
                                   32'(w_lx_eff));
    assign w_rom_addr  = w_inside ? w_addr_calc : '0;

    // ------------------------------------------------------------------
    // Stage 1: synchronous index ROM read; inside/blank delayed alongside
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] r_rom_q;
    logic             r_inside_d1;
    logic             r_blank_d1;

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            r_rom_q     <= '0;
            r_inside_d1 <= 1'b0;
            r_blank_d1  <= 1'b0;
        end else begin
            r_rom_q     <= IDX_W'(rom_lookup(32'(w_rom_addr), IDX_W));
            r_inside_d1 <= w_inside;
            r_blank_d1  <= bus.blank;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: palette lookup and registered outputs
    // ------------------------------------------------------------------
    logic    w_opaque;
    logic    w_hit_next;
    rgb444_t w_pal;
    rgb444_t r_rgb;
    logic    r_hit;

    assign w_opaque   = (r_rom_q != IDX_W'(TRANSPARENT_IDX));
    assign w_hit_next = r_blank_d1 && r_inside_d1 && w_opaque;
    assign w_pal      = palette_lookup(8'(r_rom_q));

    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            r_rgb <= '0;
            r_hit <= 1'b0;
        end else begin
            r_rgb <= w_hit_next ? w_pal : '0;
            r_hit <= w_hit_next;
        end
    end

    assign bus.red   = r_rgb.r;
    assign bus.green = r_rgb.g;
    assign bus.blue  = r_rgb.b;
    assign bus.hit   = r_hit;

endmodule : sprite_mapper
`default_nettype wire

// File: tb/tb_sprite_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_mapper
// Description : Self-checking bench for sprite_mapper (FRAME_HOLD=4,
//               NUM_FRAMES=4, 21x24 sprite, scale 4). Every driven pixel
//               pushes its expected {hit,rgb} to a scoreboard that is popped
//               two cycles later. Expected values come from hand-derived
//               ROM addresses and the bench's own ROM/palette formulas.
// Options     : SPRITE_MIRROR_EN enables the mirror sequence.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_mapper;
    import sprite_pkg::*;

    localparam int P_SPR_W  = 21;
    localparam int P_SPR_H  = 24;
    localparam int P_SCALE  = 2;
    localparam int P_FRAMES = 4;
    localparam int P_HOLD   = 4;
    localparam int P_IDX_W  = 5;
    localparam int P_TRANSP = 0;

    logic vga_clk = 1'b0;
    logic Reset;

    sprite_if bus();

    sprite_mapper #(
        .SPR_W           (P_SPR_W),
        .SPR_H           (P_SPR_H),
        .SCALE_LOG2      (P_SCALE),
        .NUM_FRAMES      (P_FRAMES),
        .FRAME_HOLD      (P_HOLD),
        .IDX_W           (P_IDX_W),
        .TRANSPARENT_IDX (P_TRANSP)
    ) dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        logic        exp_hit;
        logic [11:0] exp_rgb;
        string       name;
    } sb_t;

    sb_t sb_q[$];
    sb_t mon_e;
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    always @(posedge vga_clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic ah, input logic [11:0] ar,
                         input logic eh, input logic [11:0] er);
        total++;
        if (ah !== eh || ar !== er) begin
            bad++;
            $display("FAIL %s: got hit=%0d rgb=%03h, expected hit=%0d rgb=%03h",
                     nm, ah, ar, eh, er);
        end
    endtask

    always @(negedge vga_clk) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            if (mon_e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: scoreboard entry due at cycle %0d seen at %0d",
                         mon_e.name, mon_e.due, cyc);
            end else begin
                check(mon_e.name, bus.hit, {bus.red, bus.green, bus.blue},
                      mon_e.exp_hit, mon_e.exp_rgb);
            end
        end
    end

    // Expected {hit, rgb} for a ROM address (-1 = outside the sprite).
    function automatic logic [12:0] exp_px(input int addr, input bit blank_in);
        int idx;
        logic [3:0] r, g, b;
        if (addr < 0 || !blank_in) return 13'd0;
        idx = (addr * 7 + 3) % 32;
        if (idx == P_TRANSP) return 13'd0;
        r = 4'(idx % 16);
        g = 4'(15 - (idx % 16));
        b = 4'(((idx / 4) % 8) * 2 + 1);
        return {1'b1, r, g, b};
    endfunction

    task automatic drive(input int x, input int y, input bit b, input int addr,
                         input string nm);
        logic [12:0] e;
        sb_t ent;
        @(negedge vga_clk);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.blank = b;
        e = exp_px(addr, b);
        ent.due     = cyc + 2;
        ent.exp_hit = e[12];
        ent.exp_rgb = e[11:0];
        ent.name    = nm;
        sb_q.push_back(ent);
    endtask

    // Frame start: (0,0) held for n cycles, then leave the origin.
    task automatic frame_start(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0, -1, "fs_origin");
        drive(1, 0, 1'b0, -1, "fs_exit");
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame_start(1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge vga_clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // ------------------------------------------------------------------
    // Table of single-pixel vectors at pos=(100,50), animation frame 0
    // ------------------------------------------------------------------
    typedef struct {
        int    x;
        int    y;
        bit    b;
        int    addr;
        string nm;
    } vec_t;

    vec_t vt[13];

    initial begin
        logic [12:0] e;

        vt[0]  = '{184,  50, 1'b1,  -1, "right_edge_out"};
        vt[1]  = '{100,  50, 1'b1,   0, "corner_tl"};
        vt[2]  = '{ 99,  50, 1'b1,  -1, "left_out"};
        vt[3]  = '{183,  50, 1'b1,  20, "corner_tr"};
        vt[4]  = '{100,  49, 1'b1,  -1, "top_out"};
        vt[5]  = '{100, 145, 1'b1, 483, "corner_bl"};
        vt[6]  = '{100, 146, 1'b1,  -1, "bottom_out"};
        vt[7]  = '{183, 145, 1'b1, 503, "corner_br"};
        vt[8]  = '{124,  54, 1'b1,  27, "transparent_a"};
        vt[9]  = '{150, 100, 1'b1, 264, "middle"};
        vt[10] = '{127,  57, 1'b1,  27, "transparent_b"};
        vt[11] = '{104,  50, 1'b0,   1, "blank_low"};
        vt[12] = '{101,  53, 1'b1,   0, "same_texel"};

        Reset       = 1'b1;
        bus.DrawX   = 10'd5;
        bus.DrawY   = 10'd5;
        bus.blank   = 1'b0;
        bus.pos_x   = 10'd100;
        bus.pos_y   = 10'd50;
        bus.anim_en = 1'b1;
`ifdef SPRITE_MIRROR_EN
        bus.mirror  = 1'b0;
`endif
        repeat (2) @(negedge vga_clk);
        #2;
        check("reset_outputs", bus.hit, {bus.red, bus.green, bus.blue}, 1'b0, 12'h000);
        @(negedge vga_clk);
        Reset = 1'b0;

        // one frame start latches pos=(100,50); frame_idx stays 0
        frame_start(1);
        for (int i = 0; i < 13; i++)
            drive(vt[i].x, vt[i].y, vt[i].b, vt[i].addr, vt[i].nm);

        // position change mid-frame waits for the next frame start
        bus.pos_x = 10'd300;
        drive(100, 50, 1'b1,  0, "latch_old_hit");
        drive(300, 50, 1'b1, -1, "latch_new_miss");
        frame_start(1);
        drive(300, 50, 1'b1,  0, "latch_new_hit");
        drive(100, 50, 1'b1, -1, "latch_old_miss");

        // 4 enabled frame starts -> frame 1 (base 504)
        frames(2);
        drive(300, 50, 1'b1, 504, "anim_f1_base");
        drive(383, 50, 1'b1, 524, "anim_f1_tr");

        // disabled animation: three frames change nothing
        bus.anim_en = 1'b0;
        frames(3);
        drive(300, 50, 1'b1, 504, "anim_off_idx");
        bus.anim_en = 1'b1;
        frames(3);
        drive(300, 50, 1'b1, 504, "anim_hold_kept");

        // origin held 3 cycles counts once: 8th start -> frame 2
        frame_start(3);
        drive(300, 50, 1'b1, 1008, "origin_held_f2");
        frames(3);
        drive(300, 50, 1'b1, 1008, "origin_held_once");
        frames(1);
        drive(300, 50, 1'b1, 1512, "anim_f3");
        frames(4);
        drive(300, 50, 1'b1, 0, "anim_wrap");

        // asynchronous reset mid-line
        drive(300, 50, 1'b1, 0, "pre_reset_a");
        drive(300, 50, 1'b1, 0, "pre_reset_b");
        drain();
        #2;
        e = exp_px(0, 1'b1);
        check("pre_reset_live", bus.hit, {bus.red, bus.green, bus.blue}, e[12], e[11:0]);
        #1;
        Reset     = 1'b1;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        bus.blank = 1'b0;
        #1;
        check("reset_async", bus.hit, {bus.red, bus.green, bus.blue}, 1'b0, 12'h000);
        @(negedge vga_clk);
        Reset = 1'b0;
        // (0,0) present at release must act as a frame start (latches 300,50)
        drive(1, 0, 1'b0, -1, "post_reset_exit");
        drive(300, 50, 1'b1,  0, "post_reset_addr0");
        drive(383, 50, 1'b1, 20, "post_reset_tr");
        drive(100, 50, 1'b1, -1, "post_reset_old_pos");

`ifdef SPRITE_MIRROR_EN
        bus.mirror = 1'b1;
        frame_start(1);
        drive(300, 50, 1'b1, 20, "mirror_left");
        drive(383, 50, 1'b1,  0, "mirror_right");
        bus.mirror = 1'b0;
        frame_start(1);
        drive(300, 50, 1'b1,  0, "mirror_off");
`endif

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule : tb_sprite_mapper
`default_nettype wire

// File: doc/sprite_mapper.md
# sprite_mapper

Parametrised sprite-to-pixel mapper for the VGA path. For each (DrawX, DrawY) it decides whether the pixel lies inside a movable, integer-scaled, multi-frame animated sprite and looks up its colour through a palette ROM. It returns registered RGB plus a per-pixel `hit` flag, with a fixed 2-cycle latency. It sits between the VGA controller and the top-level colour mux, one instance per on-screen object (meteor, ship, etc.).

## Interface
Parameters:
- SPR_W, 21: sprite width in source texels
- SPR_H, 24: sprite height in source texels
- SCALE_LOG2, 2: each texel is drawn as a (1<<SCALE_LOG2)-pixel square; range 0..3
- NUM_FRAMES, 4: animation frames stored back-to-back in the ROM; range 1..16
- FRAME_HOLD, 8: video frames each animation frame is displayed; range 1..255
- IDX_W, 5: palette index width
- TRANSPARENT_IDX, 0: palette index treated as transparent

Ports:
- vga_clk  in  1  pixel clock
- Reset  in  1  asynchronous, active-high reset
- DrawX, DrawY  in  10 each  current pixel coordinates from the VGA controller
- blank  in  1  high during the active display region
- pos_x, pos_y  in  10 each  sprite top-left corner in screen pixels
- anim_en  in  1  high lets the animation advance
- red, green, blue  out  4 each  registered pixel colour
- hit  out  1  registered; high for an opaque sprite pixel inside the active region

## Operation
- Frame start is the first cycle with DrawX==0 and DrawY==0. It is detected by comparing against the registered previous coordinates, so it fires once even if (0,0) is held for several cycles.
- At frame start, pos_x/pos_y are latched into px_q/py_q. Mid-frame position changes take effect only at the next frame start.
- Containment test uses 11-bit unsigned arithmetic so the comparison cannot wrap:
  - inside = DrawX ≥ px_q, DrawX < px_q + (SPR_W<<SCALE_LOG2), and the same for Y.
  - A sprite extending past 639/479 is clipped naturally.
- Local coordinates: lx = (DrawX − px_q) >> SCALE_LOG2; ly = (DrawY − py_q) >> SCALE_LOG2.
- ROM address = frame_idx*SPR_W*SPR_H + ly*SPR_W + lx.
  - Address width is $clog2(NUM_FRAMES*SPR_W*SPR_H).
  - When outside the sprite, the address is forced to 0.
- Animation is controlled by two counters:
  - hold_cnt (8 bit) increments at each frame start while anim_en=1.
  - When hold_cnt reaches FRAME_HOLD−1, it clears to 0 and frame_idx advances.
  - frame_idx wraps from NUM_FRAMES−1 to 0.
  - With anim_en=0, both counters hold.
  - With NUM_FRAMES=1, frame_idx stays 0.
- Output stage:
  - hit = blank_d2 & inside_d2 & (rom_q ≠ TRANSPARENT_IDX).
  - RGB = palette colour when hit, otherwise 0.

## Timing
- Pipeline:
  - Cycle n: coordinates presented; address computed combinationally.
  - Cycle n+1: ROM q is registered inside the ROM; inside and blank are delayed to match.
  - Cycle n+2: red/green/blue/hit are registered at the outputs.
  - Latency is exactly 2 vga_clk cycles, with throughput of 1 pixel per cycle.
- Reset behaviour:
  - All outputs are 0 and hit is 0.
  - px_q, py_q, hold_cnt and frame_idx are 0.
  - The inside/blank delay stages are 0.
  - The previous-coordinate register is set to 0x3FF so that the first (0,0) after reset is a frame start.
- Reset asserted mid-line: outputs go to 0 asynchronously. The first valid output appears 2 cycles after Reset deasserts.
- Frame start on the same cycle as an anim_en change: the anim_en value sampled on that cycle governs.

## Configuration
- SPRITE_MIRROR_EN: when defined, adds input port `mirror` (1 bit).
  - The port is latched at frame start together with the position.
  - When the latched value is 1, lx is replaced with SPR_W−1−lx (horizontal flip).
- When SPRITE_MIRROR_EN is undefined, the port does not exist and no flip logic is built.

## Structure
- Package `sprite_pkg` holds:
  - the rgb444_t struct typedef;
  - SCREEN_W=640 and SCREEN_H=480;
  - the coordinate width constant COORD_W=10.
- Sub-module `sprite_anim_ctr` contains the frame-start detector and the hold_cnt/frame_idx counters. Its outputs are frame_start and frame_idx.
- The ROM and palette are instantiated per sprite as generated IP. The ROM is synchronous with a 1-cycle read and no output register beyond that.

## Test plan
- Reset check: assert Reset mid-line → all outputs 0 immediately; after release, frame_idx=0 and a sprite pixel at (pos) maps to address 0.
- Corners (SPR_W=21, SPR_H=24, SCALE_LOG2=2, pos=(100,50), one frame start applied):
  - (100,50) → address 0, and hit appears 2 cycles later.
  - (183,50) → address 20.
  - (184,50) → hit=0.
  - (100,145) → address 483.
- Transparency: ROM entry = TRANSPARENT_IDX at an inside pixel → hit=0 and rgb=0. With blank=0 and an opaque inside pixel → hit=0 and rgb=0.
- Position latch: change pos_x from 100 to 300 mid-frame → the rest of the frame still renders at 100; the next frame renders at 300.
- Animation (FRAME_HOLD=4, NUM_FRAMES=4):
  - After 4 frame starts, frame_idx=1, so the base address is 504.
  - After 16 frame starts, it wraps to 0.
  - Holding anim_en=0 for 3 frames leaves both counters unchanged.
  - (0,0) held for 3 cycles counts as one frame start.
- Mirror (with SPRITE_MIRROR_EN, mirror=1): pixel (100,50) → address 20.
